// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and FSM state encoding (PARITY state only with UART_RX_PARITY_EN)
package uart_pkg;

    localparam int DATA_W     = 8;
    localparam int DEF_CLK_HZ = 27000000;
    localparam int DEF_BAUD   = 115200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_IDLE
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial line, resets to idle-high
module uart_rx_sync (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_param_recv.sv
// rtl/uart_param_recv.sv - parameterised 8N1 UART receiver; define UART_RX_PARITY_EN for 8E1 with parity_err
module uart_param_recv
    import uart_pkg::*;
#(
    parameter int CLK_HZ = DEF_CLK_HZ,
    parameter int BAUD   = DEF_BAUD
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              data_rdy,
    output logic              frame_err,
`ifdef UART_RX_PARITY_EN
    output logic              parity_err,
`endif
    output logic              busy
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    logic              rxs;
    uart_state_t       state, state_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic [2:0]        bit_idx, bit_next;
    logic [DATA_W-1:0] shift, shift_next;
    logic [DATA_W-1:0] data_next;
    logic              rdy_next, ferr_next;
`ifdef UART_RX_PARITY_EN
    logic              par_bad, par_bad_next, perr_next;
`endif

    uart_rx_sync u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (rx),
        .q      (rxs)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            data       <= '0;
            data_rdy   <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            bit_idx    <= bit_next;
            shift      <= shift_next;
            data       <= data_next;
            data_rdy   <= rdy_next;
            frame_err  <= ferr_next;
`ifdef UART_RX_PARITY_EN
            par_bad    <= par_bad_next;
            parity_err <= perr_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        bit_next   = bit_idx;
        shift_next = shift;
        data_next  = data;
        rdy_next   = 1'b0;
        ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_next = par_bad;
        perr_next    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                cnt_next = '0;
                if (!rxs) state_next = ST_START;
            end
            ST_START: begin
                // Re-check the line at mid start bit so short glitches are dropped silently.
                if (cnt == HALF_M1) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rxs ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
                    par_bad_next = 1'b0;
`endif
                end
            end
            ST_DATA: begin
                if (cnt == DIV_M1) begin
                    cnt_next   = '0;
                    shift_next = {rxs, shift[DATA_W-1:1]};
                    bit_next   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt == DIV_M1) begin
                    cnt_next     = '0;
                    par_bad_next = (rxs != ^shift);
                    state_next   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (cnt == DIV_M1) begin
                    cnt_next = '0;
                    if (rxs) begin
                        state_next = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (!par_bad) begin
                            rdy_next  = 1'b1;
                            data_next = shift;
                        end
`else
                        rdy_next  = 1'b1;
                        data_next = shift;
`endif
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = ST_WAIT_IDLE;
                    end
`ifdef UART_RX_PARITY_EN
                    perr_next = par_bad;
`endif
                end
            end
            ST_WAIT_IDLE: begin
                // A held-low line (break) reports once, then waits for idle before rearming.
                cnt_next = '0;
                if (rxs) state_next = ST_IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_param_recv.sv
// tb/tb_uart_param_recv.sv - scoreboard bench for uart_param_recv at DIV=10
module tb_uart_param_recv;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 100000;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int HALF   = DIV / 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       data_rdy, frame_err, busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int rdy_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    logic [7:0] exp_q[$];

    uart_param_recv #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rx         (rx),
        .data       (data),
        .data_rdy   (data_rdy),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (data_rdy) begin
                rdy_cnt++;
                check("sb_expected_frame", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("sb_data", 32'(data), 32'(exp_q.pop_front()));
            end
            if (frame_err) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) perr_cnt++;
`endif
        end
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int rdy0, ferr0;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("rst_data", 32'(data), 32'h00);
        check("rst_data_rdy", 32'(data_rdy), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Single ideal frame 0xFE
        exp_q.push_back(8'hFE);
        send_frame(8'hFE, 1'b1);
        idle(20);
        check("fe_rdy_cnt", 32'(rdy_cnt), 32'd1);
        check("fe_data", 32'(data), 32'hFE);
        check("fe_busy", 32'(busy), 32'd0);
        check("fe_ferr", 32'(ferr_cnt), 32'd0);

        // 3-cycle glitch is rejected
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (HALF + 3) @(posedge clk);
        #1;
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_rdy", 32'(rdy_cnt), 32'd1);
        check("glitch_ferr", 32'(ferr_cnt), 32'd0);
        check("glitch_data", 32'(data), 32'hFE);

        // 0x55 with low stop bit, line held low (break)
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("brk_ferr", 32'(ferr_cnt), 32'd1);
        check("brk_data", 32'(data), 32'hFE);
        check("brk_rdy", 32'(rdy_cnt), 32'd1);
        check("brk_busy_wait", 32'(busy), 32'd1);
        idle(6);
        check("brk_busy_release", 32'(busy), 32'd0);
        check("brk_ferr_once", 32'(ferr_cnt), 32'd1);

        // Back-to-back 0x00 then 0xFF
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(20);
        check("b2b_rdy_cnt", 32'(rdy_cnt), 32'd3);
        check("b2b_data", 32'(data), 32'hFF);

        // Reset during bit 4 of 0xA5, then 0x3C
        rdy0 = rdy_cnt;
        ferr0 = ferr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'hA5 >> i));
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 resetn = 1'b0;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        idle(25);
        check("rst_mid_data", 32'(data), 32'h00);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_rdy", 32'(rdy_cnt), 32'(rdy0));
        check("rst_mid_ferr", 32'(ferr_cnt), 32'(ferr0));
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        idle(20);
        check("post_rst_rdy", 32'(rdy_cnt), 32'(rdy0 + 1));
        check("post_rst_data", 32'(data), 32'h3C);

`ifdef UART_RX_PARITY_EN
        // 0x07 with wrong parity (0), then correct parity (1)
        rdy0 = rdy_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'(8'h07 >> i));
        send_bit(1'b0);
        send_bit(1'b1);
        idle(20);
        check("par_bad_perr", 32'(perr_cnt), 32'd1);
        check("par_bad_rdy", 32'(rdy_cnt), 32'(rdy0));
        check("par_bad_data", 32'(data), 32'h3C);
        exp_q.push_back(8'h07);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'(8'h07 >> i));
        send_bit(1'b1);
        send_bit(1'b1);
        idle(20);
        check("par_ok_perr", 32'(perr_cnt), 32'd1);
        check("par_ok_rdy", 32'(rdy_cnt), 32'(rdy0 + 1));
        check("par_ok_data", 32'(data), 32'h07);
`endif

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_param_recv.md
UART_PARAM_RECV -- requirements
Module: uart_param_recv

Interface
REQ-001 Parameter CLK_HZ, default 27000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line bit rate in bit/s.
REQ-003 Port clk  input  1  system clock; all logic on rising edge.
REQ-004 Port resetn  input  1  reset; asynchronous assert, active-low.
REQ-005 Port rx  input  1  asynchronous serial line, idle high.
REQ-006 Port data  output  8  last correctly received byte.
REQ-007 Port data_rdy  output  1  one-cycle pulse: new byte valid on data.
REQ-008 Port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 Port busy  output  1  high while any frame is in progress (state != IDLE).
REQ-010 Port parity_err  output  1  one-cycle pulse: parity mismatch (present only with UART_RX_PARITY_EN).

Function
REQ-011 Bit period DIV = CLK_HZ/BAUD (integer floor); half period HALF = DIV/2; counter width sized by $clog2(DIV).
REQ-012 rx passes through a 2-flop synchronizer, reset value 1; all decisions use the synchronized value rxs.
REQ-013 States: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
REQ-014 IDLE: on rxs==0, go START and clear baud counter.
REQ-015 START: after HALF cycles sample rxs; 0 -> DATA (counter reset); 1 -> IDLE, no outputs pulsed (glitch rejected).
REQ-016 DATA: sample rxs every DIV cycles; 8 bits, LSB first, shifted into internal register; after bit 7 -> PARITY (macro) or STOP.
REQ-017 STOP: sample after DIV cycles; 1 -> data loaded from shift register, data_rdy pulses, go IDLE; 0 -> frame_err pulses, data unchanged, go WAIT_IDLE.
REQ-018 data_rdy/frame_err assert exactly one cycle, in the cycle following the stop-bit sample.
REQ-019 WAIT_IDLE: stay until rxs==1, then IDLE (break condition yields one frame_err only).
REQ-020 data holds its value until the next valid frame; never changes on error or glitch.
REQ-021 Back-to-back frames: a start edge in the cycle after the stop sample is accepted without loss.
REQ-022 Sampling point error: each sample within +-1 clk of nominal mid-bit for DIV>=8; DIV<4 is unsupported.

Reset
REQ-023 resetn low asynchronously forces: state IDLE, counters 0, shift register 0, data=8'h00, data_rdy=0, frame_err=0, parity_err=0, busy=0, synchronizer flops 1.
REQ-024 Reset mid-frame discards the partial byte; after release, reception restarts only on a new falling edge of rxs.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: port parity_err and state PARITY exist; one even-parity bit follows bit 7, sampled after DIV cycles; mismatch -> parity_err pulses with data_rdy suppressed and data unchanged, FSM still evaluates STOP (frame_err may pulse in the same cycle).
REQ-026 Macro undefined: 8N1 only; no PARITY state, no parity_err port.

Structure
REQ-027 Shared package uart_pkg holds the FSM state encoding, data width constant (8) and default CLK_HZ/BAUD, shared with uart_param_trans.
REQ-028 One sub-module uart_rx_sync (2-flop synchronizer, reset-to-1) is instantiated; all else in uart_param_recv.

Verification (CLK_HZ=1000000, BAUD=100000, DIV=10)
REQ-029 Frame 0xFE, 8N1, ideal timing -> one data_rdy pulse, data==8'hFE, busy low afterward, frame_err never high.
REQ-030 rx low for 3 cycles then high -> no data_rdy, no frame_err, busy back to 0 within HALF+3 cycles.
REQ-031 Frame 0x55 with stop bit low, line held low 30 cycles -> exactly one frame_err, data keeps previous value, no new frame until rx high.
REQ-032 Frames 0x00 then 0xFF with zero idle gap -> two data_rdy pulses, values 8'h00 then 8'hFF.
REQ-033 resetn pulsed low during bit 4 of 0xA5, then full frame 0x3C -> no output for 0xA5, data==8'h3C after second frame.
REQ-034 With UART_RX_PARITY_EN, frame 0x07 with wrong parity bit 0 -> parity_err pulse, no data_rdy; with correct bit 1 -> data_rdy, data==8'h07.
